// File: rtl/mic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mic_pkg : shared types and constants for the MIC request arbiter |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_t;

  // Matches the controller's two-stage read pipeline depth.
  localparam int MIC_READ_HOLDOFF = 2;

endpackage
`default_nettype wire

// File: rtl/mic_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mic_rr_pick : round-robin winner select (rotate/encode/unrotate) |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mic_rr_pick #(
  parameter int NREQS = 4,
  parameter int NBITS = $clog2(NREQS)
) (
  input  logic [NREQS-1:0] req,
  input  logic [NBITS-1:0] pointer,
  output logic             found,
  output logic [NBITS-1:0] winner
);

  logic [NREQS-1:0] w_rotated;
  logic [NBITS-1:0] w_src;
  logic [NBITS-1:0] w_offset;

  always_comb begin
    w_rotated = '0;
    w_src     = '0;
    // Bit i of the rotated vector is requester (pointer+1+i) mod NREQS.
    for (int i = 0; i < NREQS; i++) begin
      w_src        = NBITS'((int'(pointer) + 1 + i) % NREQS);
      w_rotated[i] = req[w_src];
    end

    found    = 1'b0;
    w_offset = '0;
    for (int i = NREQS - 1; i >= 0; i--) begin
      if (w_rotated[i]) begin
        found    = 1'b1;
        w_offset = NBITS'(i);
      end
    end

    winner = NBITS'((int'(pointer) + 1 + int'(w_offset)) % NREQS);
  end

endmodule
`default_nettype wire

// File: rtl/mic_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mic_rr_arbiter : round-robin arbiter in front of the MIC, with a |
// | post-read hold-off so the controller pipeline drains.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mic_rr_arbiter
  import mic_pkg::*;
#(
  parameter int NREQS        = 4,
  parameter int NBITS        = $clog2(NREQS),
  parameter int READ_HOLDOFF = MIC_READ_HOLDOFF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQS-1:0] req_valid,
  input  logic [NREQS-1:0] req_is_write,
  input  logic             fifo_empty,
  output logic             req_read,
  output logic             req_write,
  output logic             arb_grant,
  output logic [NBITS-1:0] arb_grant_index,
  output logic [NREQS-1:0] grant_onehot
);

  localparam logic [3:0] c_holdoff_load =
    (READ_HOLDOFF > 0) ? 4'(READ_HOLDOFF - 1) : 4'd0;

  arb_state_t       r_state, w_state_nxt;
  logic [3:0]       r_count, w_count_nxt;
  logic [NBITS-1:0] r_pointer, w_pointer_nxt;

  logic             w_found;
  logic [NBITS-1:0] w_winner;

  logic             w_read_nxt, w_write_nxt, w_grant_nxt;
  logic [NBITS-1:0] w_index_nxt;
  logic [NREQS-1:0] w_onehot_nxt;

  mic_rr_pick #(
    .NREQS (NREQS),
    .NBITS (NBITS)
  ) u_pick (
    .req     (req_valid),
    .pointer (r_pointer),
    .found   (w_found),
    .winner  (w_winner)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_pointer_nxt = r_pointer;
    w_read_nxt    = 1'b0;
    w_write_nxt   = 1'b0;
    w_grant_nxt   = 1'b0;
    w_index_nxt   = '0;
    w_onehot_nxt  = '0;

    case (r_state)
      IDLE: begin
        if (w_found && !fifo_empty) begin
          w_grant_nxt            = 1'b1;
          w_index_nxt            = w_winner;
          w_onehot_nxt[w_winner] = 1'b1;
          w_write_nxt            = req_is_write[w_winner];
          w_read_nxt             = !req_is_write[w_winner];
          w_state_nxt            = GRANT;
        end
      end
      GRANT: begin
        // The registered grant outputs still hold the winner this cycle.
        w_pointer_nxt = arb_grant_index;
        if (req_read && (READ_HOLDOFF > 0)) begin
          w_state_nxt = HOLDOFF;
          w_count_nxt = c_holdoff_load;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HOLDOFF: begin
        if (r_count == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_count         <= 4'd0;
      r_pointer       <= NBITS'(NREQS - 1);
      req_read        <= 1'b0;
      req_write       <= 1'b0;
      arb_grant       <= 1'b0;
      arb_grant_index <= '0;
      grant_onehot    <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_count         <= w_count_nxt;
      r_pointer       <= w_pointer_nxt;
      req_read        <= w_read_nxt;
      req_write       <= w_write_nxt;
      arb_grant       <= w_grant_nxt;
      arb_grant_index <= w_index_nxt;
      grant_onehot    <= w_onehot_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/mic_rr_arbiter.md
Name: mic_rr_arbiter

Overview:
- Round-robin arbiter that shares the single memory-interface controller between NREQS requesters.
- Picks one pending request per decision and drives the controller's req_read/req_write/arb_grant/arb_grant_index inputs.
- Inserts a hold-off window after each read grant so the controller's two-stage pipeline drains before the next grant.
- Also returns a one-hot grant to the requesters.

Parameters:
- NREQS, 4, number of requesters; must be >= 2.
- NBITS, $clog2(NREQS), width of arb_grant_index.
- READ_HOLDOFF, 2, idle cycles after a read grant before the next decision; legal range 0..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  NREQS  per-requester request pending.
- req_is_write  input  NREQS  per-requester: 1 = write, 0 = read; meaningful only with the matching req_valid bit.
- fifo_empty  input  1  command FIFO empty; no grant is issued while it is 1.
- req_read  output  1  granted request is a read; to the controller.
- req_write  output  1  granted request is a write; to the controller.
- arb_grant  output  1  one-cycle grant strobe; to the controller.
- arb_grant_index  output  NBITS  index of the granted requester.
- grant_onehot  output  NREQS  one-hot grant back to the requesters; equals 1 << arb_grant_index while arb_grant=1, else 0.

Behaviour:
- Clock and reset: one clock, clock, rising edge. reset_n is synchronous and active-low, sampled on the rising edge of clock.
- Reset values:
  - req_read, req_write, arb_grant, grant_onehot = 0; arb_grant_index = 0.
  - State = IDLE; holdoff counter = 0; last-grant pointer = NREQS-1, so requester 0 has first priority.
- Reset mid-grant or mid-holdoff: the next edge returns everything to reset values; any in-flight grant is dropped.
- All outputs are registered.
- State IDLE:
  - Decision taken when any req_valid bit is 1 and fifo_empty=0.
  - Winner = first set req_valid bit, scanning from (pointer+1) mod NREQS upward with wrap-around.
  - The winner and its req_is_write bit are captured on that edge; next state is GRANT.
  - Otherwise stay in IDLE.
- State GRANT, exactly one cycle:
  - arb_grant=1; arb_grant_index=winner; grant_onehot set.
  - req_read=!is_write and req_write=is_write; exactly one of the two is 1.
  - Pointer updates to winner.
  - Next state: HOLDOFF if the grant was a read and READ_HOLDOFF>0; otherwise IDLE.
  - Latency: request visible in IDLE at edge N gives the grant asserted during cycle N+1.
  - Back-to-back writes are therefore granted every second cycle.
- State HOLDOFF:
  - Counter loaded with READ_HOLDOFF-1 on entry and decremented each cycle; all outputs 0.
  - Returns to IDLE when the counter is 0.
  - Requests and fifo_empty are ignored in this state.
- Requester protocol:
  - req_valid and req_is_write are held stable until the requester's grant_onehot bit is seen.
  - Retraction before grant is a protocol violation: the arbiter may still grant the stale request.
  - After its grant the requester deasserts req_valid in the grant cycle, or re-requests, which is treated as a new request.
- fifo_empty=1 in IDLE: no decision; the pointer is unchanged.
- A single requester pending is granted repeatedly; no fairness penalty.
- Only one req_valid bit set that equals pointer+1 with wrap-around (e.g. pointer=NREQS-1 and bit 0) is handled correctly.
- Fairness: with all requesters continuously valid, grant indices cycle 0,1,…,NREQS-1,0,…
- Assertions in the bench:
  - arb_grant and grant_onehot are consistent.
  - Never req_read and req_write together.
  - No grant while in HOLDOFF.

Decomposition:
- Package mic_pkg holds:
  - The state enum arb_state_t {IDLE, GRANT, HOLDOFF}.
  - Default READ_HOLDOFF constant MIC_READ_HOLDOFF = 2, matching the controller pipeline depth.
- One combinational sub-module, mic_rr_pick:
  - Inputs: req vector and pointer.
  - Outputs: found flag and winner index.
  - Implemented as a rotate / priority-encode / un-rotate.

Test Plan:
- Reset: hold reset_n=0 for 3 edges with all req_valid=1 -> all outputs 0; after release, first grant index 0 appears 2 edges after reset_n rises.
- Rotation: NREQS=4, all req_valid=1, all writes, fifo_empty=0 -> indices 0,1,2,3,0 with arb_grant pulses every 2 cycles; req_write=1, req_read=0 each time.
- Read holdoff: requester 2 read only, READ_HOLDOFF=2 -> grant at cycle 1, outputs 0 in cycles 2-4, next grant for the re-request at cycle 5; req_read=1 in the grant cycles.
- Wrap and fifo gating: pointer=3, req_valid=4'b0001, fifo_empty=1 for 5 cycles then 0 -> no grant while empty; grant index 0 one cycle after fifo_empty falls.
- Mixed read/write: req_valid=4'b1010, req_is_write=4'b1000 -> index 1 read (holdoff follows), then index 3 write, then back to index 1.
- Reset mid-holdoff: assert reset_n=0 during the HOLDOFF after a read -> next edge all outputs 0 and pointer=3; the following grant goes to the lowest pending index.
